// File: rtl/riscV_unrn_pkg.sv
// Shared RISC-V machine-mode definitions: CSR layouts, trap cause codes and
// the trap sequencer state encoding.
package riscV_unrn_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [18:0] rsvd_31_13;
        logic [1:0]  mpp;
        logic [2:0]  rsvd_10_8;
        logic        mpie;
        logic [2:0]  rsvd_6_4;
        logic        mie;
        logic [2:0]  rsvd_2_0;
    } mstatus_csr_t;

    typedef struct packed {
        logic [19:0] rsvd_31_12;
        logic        meip;
        logic [2:0]  rsvd_10_8;
        logic        mtip;
        logic [6:0]  rsvd_6_0;
    } mip_csr_t;

    typedef struct packed {
        logic [19:0] rsvd_31_12;
        logic        meie;
        logic [2:0]  rsvd_10_8;
        logic        mtie;
        logic [6:0]  rsvd_6_0;
    } mie_csr_t;

    localparam logic [XLEN-1:0] SUPPORTED_INTERRUPTS_MASK = 32'h0000_0880;

    localparam logic [XLEN-1:0] CAUSE_ILLEGAL_INSN = 32'd2;
    localparam logic [XLEN-1:0] CAUSE_BREAKPOINT   = 32'd3;
    localparam logic [XLEN-1:0] CAUSE_ECALL_M      = 32'd11;
    localparam logic [XLEN-1:0] CAUSE_M_EXT_INT    = 32'h8000_000B;
    localparam logic [XLEN-1:0] CAUSE_M_TIMER_INT  = 32'h8000_0007;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        COMMIT   = 3'd2,
        REDIRECT = 3'd3,
        MRET     = 3'd4
    } trap_state_t;

endpackage

// File: rtl/trap_ctrl_if.sv
// Flush / CSR-commit / redirect port between trap_ctrl (master) and the
// pipeline plus CSR file (slave).
interface trap_ctrl_if;
    import riscV_unrn_pkg::*;

    // flush_req_o is a level held until flush_ack_i is sampled high; csr_we_o
    // and redirect_valid_o are single-cycle strobes qualifying their data.
    logic            flush_req_o;
    logic            flush_ack_i;
    logic            csr_we_o;
    logic [XLEN-1:0] mepc_o;
    logic [XLEN-1:0] mcause_o;
    logic [XLEN-1:0] mtval_o;
    logic [XLEN-1:0] mstatus_o;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;

    modport master (
        output flush_req_o, csr_we_o, mepc_o, mcause_o, mtval_o, mstatus_o,
               redirect_valid_o, redirect_pc_o,
        input  flush_ack_i
    );

    modport slave (
        input  flush_req_o, csr_we_o, mepc_o, mcause_o, mtval_o, mstatus_o,
               redirect_valid_o, redirect_pc_o,
        output flush_ack_i
    );
endinterface

// File: rtl/irq_sync.sv
// Two-flop synchronizer for a level signal crossing into the clk domain.
module irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;
endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: flush, CSR commit and fetch redirect for
// exceptions, interrupts and MRET. Optional macro VECTORED_INT_EN.
module trap_ctrl
    import riscV_unrn_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ext_irq_i,
    input  logic            timer_irq_i,
    input  logic            exc_valid_i,
    input  logic [XLEN-1:0] exc_cause_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic            mret_i,
    input  logic            boundary_i,
    input  logic [XLEN-1:0] next_pc_i,
    input  logic [XLEN-1:0] mstatus_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic [XLEN-1:0] mip_o,
    output logic            busy_o,
    output trap_state_t     state_o,
    trap_ctrl_if.master     bus
);
    trap_state_t     r_state, w_state_nx;
    logic            w_meip;
    mip_csr_t        w_mip;
    mstatus_csr_t    w_ms_in, w_ms_trap, w_ms_mret;
    logic [XLEN-1:0] w_irq_bits;
    logic            w_irq_pending;
    logic            w_take_irq;
    logic [XLEN-1:0] w_trap_target;
    logic [XLEN-1:0] r_cause, r_epc, r_tval;
    logic [XLEN-1:0] r_mepc, r_mcause, r_mtval, r_mstatus, r_redirect_pc;
    logic            w_unused;

    irq_sync u_ext_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (ext_irq_i),
        .o_sync  (w_meip)
    );

    always_comb begin
        w_mip      = '0;
        w_mip.meip = w_meip;
        w_mip.mtip = timer_irq_i;
    end
    assign mip_o = w_mip;

    always_comb begin
        w_ms_in        = mstatus_csr_t'(mstatus_i);
        w_ms_trap      = w_ms_in;
        w_ms_trap.mpie = w_ms_in.mie;
        w_ms_trap.mie  = 1'b0;
        w_ms_trap.mpp  = 2'b11;
        w_ms_mret      = w_ms_in;
        w_ms_mret.mie  = w_ms_in.mpie;
        w_ms_mret.mpie = 1'b1;
        w_ms_mret.mpp  = 2'b11;
    end

    assign w_irq_bits    = mip_o & mie_i & SUPPORTED_INTERRUPTS_MASK;
    assign w_irq_pending = (w_irq_bits != '0) && w_ms_in.mie;
    assign w_take_irq    = w_irq_pending && boundary_i;

`ifdef VECTORED_INT_EN
    // Only interrupts are vectored; exceptions land on the base address.
    always_comb begin
        w_trap_target = {mtvec_i[XLEN-1:2], 2'b00};
        if (mtvec_i[1:0] == 2'b01 && r_cause[XLEN-1])
            w_trap_target = w_trap_target + {25'b0, r_cause[4:0], 2'b00};
    end
    assign w_unused = ^{r_epc[1:0]};
`else
    assign w_trap_target = {mtvec_i[XLEN-1:2], 2'b00};
    assign w_unused      = ^{r_epc[1:0], mtvec_i[1:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE: begin
                if (exc_valid_i)     w_state_nx = FLUSH;
                else if (mret_i)     w_state_nx = MRET;
                else if (w_take_irq) w_state_nx = FLUSH;
            end
            FLUSH:    if (bus.flush_ack_i) w_state_nx = COMMIT;
            COMMIT:   w_state_nx = REDIRECT;
            REDIRECT: w_state_nx = IDLE;
            MRET:     w_state_nx = IDLE;
            default:  w_state_nx = IDLE;
        endcase
    end

    // Trap record is captured on entry; CSR data is staged while the flush
    // completes so the commit cycle drives only registered values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cause       <= '0;
            r_epc         <= '0;
            r_tval        <= '0;
            r_mepc        <= '0;
            r_mcause      <= '0;
            r_mtval       <= '0;
            r_mstatus     <= '0;
            r_redirect_pc <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (exc_valid_i) begin
                        r_cause <= exc_cause_i;
                        r_epc   <= exc_pc_i;
                        r_tval  <= exc_tval_i;
                    end else if (mret_i) begin
                        r_mstatus     <= w_ms_mret;
                        r_redirect_pc <= mepc_i;
                    end else if (w_take_irq) begin
                        r_cause <= w_irq_bits[11] ? CAUSE_M_EXT_INT : CAUSE_M_TIMER_INT;
                        r_epc   <= next_pc_i;
                        r_tval  <= '0;
                    end
                end
                FLUSH: begin
                    if (bus.flush_ack_i) begin
                        r_mepc    <= {r_epc[XLEN-1:2], 2'b00};
                        r_mcause  <= r_cause;
                        r_mtval   <= r_tval;
                        r_mstatus <= w_ms_trap;
                    end
                end
                COMMIT:  r_redirect_pc <= w_trap_target;
                default: ;
            endcase
        end
    end

    assign busy_o               = (r_state != IDLE);
    assign state_o              = r_state;
    assign bus.flush_req_o      = (r_state == FLUSH);
    assign bus.csr_we_o         = (r_state == COMMIT) || (r_state == MRET);
    assign bus.redirect_valid_o = (r_state == REDIRECT) || (r_state == MRET);
    assign bus.mepc_o           = r_mepc;
    assign bus.mcause_o         = r_mcause;
    assign bus.mtval_o          = r_mtval;
    assign bus.mstatus_o        = r_mstatus;
    assign bus.redirect_pc_o    = r_redirect_pc;
endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized traps
// checked against a behavioural model; honours VECTORED_INT_EN.
module tb_trap_ctrl;
  import riscV_unrn_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ext_irq_i, timer_irq_i, exc_valid_i, mret_i, boundary_i;
  logic [XLEN-1:0] exc_cause_i, exc_pc_i, exc_tval_i, next_pc_i;
  logic [XLEN-1:0] mstatus_i, mie_i, mtvec_i, mepc_i, mip_o;
  logic            busy_o;
  trap_state_t     state_o;

  trap_ctrl_if bus ();

  trap_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ext_irq_i   (ext_irq_i),
    .timer_irq_i (timer_irq_i),
    .exc_valid_i (exc_valid_i),
    .exc_cause_i (exc_cause_i),
    .exc_pc_i    (exc_pc_i),
    .exc_tval_i  (exc_tval_i),
    .mret_i      (mret_i),
    .boundary_i  (boundary_i),
    .next_pc_i   (next_pc_i),
    .mstatus_i   (mstatus_i),
    .mie_i       (mie_i),
    .mtvec_i     (mtvec_i),
    .mepc_i      (mepc_i),
    .mip_o       (mip_o),
    .busy_o      (busy_o),
    .state_o     (state_o),
    .bus         (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_csr_we = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] model_ms_trap(input logic [31:0] ms);
    logic [31:0] r;
    r = ms & ~32'h0000_1888;
    r = r | 32'h0000_1800;
    if (ms[3]) r = r | 32'h0000_0080;
    return r;
  endfunction

  function automatic logic [31:0] model_ms_mret(input logic [31:0] ms);
    logic [31:0] r;
    r = ms & ~32'h0000_1888;
    r = r | 32'h0000_1880;
    if (ms[7]) r = r | 32'h0000_0008;
    return r;
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] tvec, input logic [31:0] cause);
    logic [31:0] base;
    base = tvec - (tvec % 4);
`ifdef VECTORED_INT_EN
    if ((tvec % 4) == 1 && cause >= 32'h8000_0000) base = base + 4 * (cause % 32);
`endif
    return base;
  endfunction

  // scoreboard: every redirect must match the oldest expected target
  always @(negedge clk) begin
    if (rst_n && bus.csr_we_o) n_csr_we++;
    if (rst_n && bus.redirect_valid_o) begin
      if (exp_q.size() == 0) check_eq("redirect_unexpected", 32'd1, 32'd0);
      else check_eq("redirect_pc", bus.redirect_pc_o, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exc_valid_i = 1'b0;
    mret_i = 1'b0;
    boundary_i = 1'b0;
    bus.flush_ack_i = 1'b0;
  endtask

  // Called in cycle 1 of a trap; walks flush, commit and redirect.
  task automatic finish_trap(input logic [31:0] cause, input logic [31:0] epc,
                             input logic [31:0] tval, input int ack_dly);
    logic [31:0] ms_exp;
    ms_exp = model_ms_trap(mstatus_i);
    check_eq("flush_req_c1", bus.flush_req_o, 1'b1);
    check_eq("busy_c1", busy_o, 1'b1);
    for (int i = 0; i < ack_dly; i++) begin
      step();
      check_eq("flush_hold", bus.flush_req_o, 1'b1);
      check_eq("no_early_we", bus.csr_we_o, 1'b0);
    end
    bus.flush_ack_i = 1'b1;
    step();
    bus.flush_ack_i = 1'b0;
    check_eq("commit_we", bus.csr_we_o, 1'b1);
    check_eq("flush_drop", bus.flush_req_o, 1'b0);
    check_eq("commit_no_redir", bus.redirect_valid_o, 1'b0);
    check_eq("mepc", bus.mepc_o, epc - (epc % 4));
    check_eq("mcause", bus.mcause_o, cause);
    check_eq("mtval", bus.mtval_o, tval);
    check_eq("mstatus_trap", bus.mstatus_o, ms_exp);
    exp_q.push_back(model_target(mtvec_i, cause));
    step();
    check_eq("redirect_valid", bus.redirect_valid_o, 1'b1);
    check_eq("redirect_no_we", bus.csr_we_o, 1'b0);
    step();
    check_eq("idle_after_trap", busy_o, 1'b0);
    check_eq("redirect_once", bus.redirect_valid_o, 1'b0);
  endtask

  task automatic run_exc(input logic [31:0] cause, input logic [31:0] pc,
                         input logic [31:0] tval, input int ack_dly, input bit noise);
    check_eq("exc_start_idle", busy_o, 1'b0);
    exc_valid_i = 1'b1;
    exc_cause_i = cause;
    exc_pc_i = pc;
    exc_tval_i = tval;
    mret_i = noise;
    boundary_i = noise;
    step();
    idle_inputs();
    finish_trap(cause, pc, tval, ack_dly);
  endtask

  task automatic run_irq(input bit ext, input bit tmr, input logic [31:0] mie,
                         input logic [31:0] ms, input logic [31:0] npc, input int ack_dly);
    logic [31:0] cause;
    ext_irq_i = ext;
    timer_irq_i = tmr;
    mie_i = mie;
    mstatus_i = ms;
    repeat (3) step();
    check_eq("mip", mip_o, (ext ? 32'h800 : 32'h0) + (tmr ? 32'h80 : 32'h0));
    check_eq("no_trap_off_boundary", busy_o, 1'b0);
    cause = (ext && mie[11]) ? 32'h8000_000B : 32'h8000_0007;
    boundary_i = 1'b1;
    next_pc_i = npc;
    step();
    boundary_i = 1'b0;
    finish_trap(cause, npc, 32'h0, ack_dly);
    ext_irq_i = 1'b0;
    timer_irq_i = 1'b0;
    repeat (3) step();
  endtask

  task automatic run_mret(input logic [31:0] ms, input logic [31:0] epc);
    mstatus_i = ms;
    mepc_i = epc;
    mret_i = 1'b1;
    exp_q.push_back(epc);
    step();
    mret_i = 1'b0;
    check_eq("mret_we", bus.csr_we_o, 1'b1);
    check_eq("mret_redir", bus.redirect_valid_o, 1'b1);
    check_eq("mret_busy", busy_o, 1'b1);
    check_eq("mret_mstatus", bus.mstatus_o, model_ms_mret(ms));
    step();
    check_eq("mret_busy_drop", busy_o, 1'b0);
    check_eq("mret_we_drop", bus.csr_we_o, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy_o, 1'b0);
    check_eq({tag, "_flush"}, bus.flush_req_o, 1'b0);
    check_eq({tag, "_we"}, bus.csr_we_o, 1'b0);
    check_eq({tag, "_redir"}, bus.redirect_valid_o, 1'b0);
    check_eq({tag, "_data"}, bus.mepc_o | bus.mcause_o | bus.mtval_o | bus.mstatus_o, 32'h0);
    check_eq({tag, "_rpc"}, bus.redirect_pc_o, 32'h0);
    check_eq({tag, "_mip"}, mip_o, 32'h0);
    check_eq({tag, "_state"}, 32'(state_o), 32'(IDLE));
  endtask

  initial begin
    int we_before;
    rst_n = 1'b0;
    ext_irq_i = 1'b0;
    timer_irq_i = 1'b0;
    exc_cause_i = '0;
    exc_pc_i = '0;
    exc_tval_i = '0;
    next_pc_i = '0;
    mstatus_i = '0;
    mie_i = '0;
    mtvec_i = 32'h200;
    mepc_i = '0;
    idle_inputs();
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // illegal instruction, ack tied high, mie set beforehand
    mstatus_i = 32'h0000_0008;
    run_exc(32'd2, 32'h100, 32'hFFFF_FFFF, 0, 1'b0);

    // external interrupt with synchronizer lag
    mie_i = 32'h800;
    ext_irq_i = 1'b1;
    step();
    check_eq("meip_lag1", mip_o[11], 1'b0);
    step();
    check_eq("meip_lag2", mip_o[11], 1'b1);
    run_irq(1'b1, 1'b0, 32'h800, 32'h8, 32'h44, 1);

    // masked by mstatus.mie = 0: no trap even at a boundary
    ext_irq_i = 1'b1;
    timer_irq_i = 1'b1;
    mie_i = 32'h880;
    mstatus_i = 32'h0000_1880;
    repeat (3) step();
    boundary_i = 1'b1;
    repeat (3) step();
    check_eq("masked_no_trap", busy_o, 1'b0);
    boundary_i = 1'b0;

    // simultaneous ext + timer, MRET, then timer alone
    run_irq(1'b1, 1'b1, 32'h880, 32'h8, 32'h80, 0);
    run_mret(32'h0000_1880, 32'h80);
    run_irq(1'b0, 1'b1, 32'h880, 32'h8, 32'h84, 2);

    // vectored timer interrupt
    mtvec_i = 32'h201;
    run_irq(1'b0, 1'b1, 32'h080, 32'h8, 32'h90, 0);
`ifdef VECTORED_INT_EN
    check_eq("vector_model", model_target(32'h201, 32'h8000_0007), 32'h21C);
`else
    check_eq("vector_model", model_target(32'h201, 32'h8000_0007), 32'h200);
`endif
    // exceptions ignore vectoring
    run_exc(32'd11, 32'h122, 32'h0, 0, 1'b1);
    mtvec_i = 32'h200;

    // MRET with mpie = 1
    run_mret(32'h0000_0080, 32'h300);

    // randomized traps
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      mtvec_i = {$urandom_range(0, 32'h3FFF_FFFF), 2'($urandom_range(0, 1))};
      if (kind == 0) begin
        logic [31:0] c;
        int sel;
        sel = $urandom_range(0, 2);
        c = (sel == 0) ? 32'd2 : (sel == 1) ? 32'd3 : 32'd11;
        mstatus_i = $urandom();
        run_exc(c, $urandom(), $urandom(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end else if (kind == 1) begin
        logic [31:0] m;
        logic [1:0] r;
        int sel;
        sel = $urandom_range(1, 3);
        r = 2'($urandom_range(1, 3));
        m = ($urandom() & ~32'h880) | ((sel == 1) ? 32'h800 : (sel == 2) ? 32'h080 : 32'h880);
        if (sel == 1) r[1] = 1'b1;
        if (sel == 2) r[0] = 1'b1;
        run_irq(r[1], r[0], m, $urandom() | 32'h8, $urandom(), $urandom_range(0, 3));
      end else begin
        run_mret($urandom(), $urandom());
      end
    end

    // abort: flush never acknowledged, reset pulsed mid-sequence
    mtvec_i = 32'h200;
    mstatus_i = 32'h8;
    exc_valid_i = 1'b1;
    exc_cause_i = 32'd3;
    exc_pc_i = 32'h400;
    exc_tval_i = 32'h0;
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      check_eq("abort_flush_hold", bus.flush_req_o, 1'b1);
      step();
    end
    we_before = n_csr_we;
    #2;
    rst_n = 1'b0;
    #2;
    check_all_zero("abort");
    step();
    rst_n = 1'b1;
    repeat (8) step();
    check_eq("abort_no_we", 32'(n_csr_we), 32'(we_before));
    check_eq("abort_idle", busy_o, 1'b0);
    check_eq("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer between the core pipeline and the CSR file. Takes synchronous exceptions (illegal instruction, breakpoint, ECALL), enabled external/timer interrupts, and MRET. Runs a flush/commit/redirect handshake: it writes mepc, mcause, mtval and mstatus through a dedicated CSR update port, then redirects fetch. It also builds the architectural mip value from the raw interrupt lines.

## Interface
- XLEN, 32, datapath width
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ext_irq_i  in  1  raw external interrupt level, asynchronous to clk
- timer_irq_i  in  1  timer compare level, synchronous to clk
- exc_valid_i  in  1  exception from the retiring instruction
- exc_cause_i  in  XLEN  exception code: 2, 3 or 11
- exc_pc_i  in  XLEN  pc of the faulting instruction
- exc_tval_i  in  XLEN  trap value (instruction bits or 0)
- mret_i  in  1  MRET is retiring
- boundary_i  in  1  core is at an instruction boundary, so an interrupt may be taken
- next_pc_i  in  XLEN  pc of the next instruction not yet executed
- mstatus_i  in  XLEN  current mstatus (mstatus_csr_t)
- mie_i  in  XLEN  current mie (mie_csr_t)
- mtvec_i, mepc_i  in  XLEN  current CSR values
- mip_o  out  XLEN  mip value (mip_csr_t) returned to the CSR read mux
- busy_o  out  1  high in every state except IDLE; the core stalls retirement while it is high
- flush_req_o  out  1  request to kill in-flight instructions
- flush_ack_i  in  1  pipeline is empty
- csr_we_o  out  1  one-cycle strobe that commits all of the following outputs together
- mepc_o, mcause_o, mtval_o, mstatus_o  out  XLEN  trap CSR write data
- redirect_valid_o  out  1  one-cycle fetch redirect
- redirect_pc_o  out  XLEN  redirect target

## Operation
- mip_o: meip = ext_irq_i after a 2-flop synchronizer; mtip = timer_irq_i; every other bit is 0.
- An interrupt is pending when (mip_o & mie_i & 32'h880) != 0 and mstatus_i.mie == 1.
- Priority, evaluated in IDLE only: exc_valid_i, then mret_i, then pending interrupt with boundary_i. Between interrupts, external (11) wins over timer (7).
- States and transitions:
  - IDLE to FLUSH on an exception or an interrupt. On entry, latch cause, epc and tval:
    - exception: cause = exc_cause_i, epc = exc_pc_i, tval = exc_tval_i
    - interrupt: cause = 32'h8000_000B or 32'h8000_0007, epc = next_pc_i, tval = 0
  - IDLE to MRET on mret_i.
  - FLUSH holds flush_req_o high until flush_ack_i is seen, then goes to COMMIT.
  - COMMIT asserts csr_we_o for one cycle, then goes to REDIRECT. The write values are:
    - mepc_o = {epc[31:2], 2'b00}
    - mcause_o = cause
    - mtval_o = tval
    - mstatus_o = mstatus_i with mpie = mie, mie = 0, mpp = 2'b11
  - REDIRECT asserts redirect_valid_o for one cycle with redirect_pc_o = trap target, then goes to IDLE.
  - MRET asserts csr_we_o with mstatus_o = mstatus_i with mie = mpie, mpie = 1, mpp = 2'b11. In the same cycle it asserts redirect_valid_o with redirect_pc_o = mepc_i, then goes to IDLE.
- Trap target = {mtvec_i[31:2], 2'b00}, subject to the Configuration section.
- Inputs are ignored outside IDLE. An interrupt that arrives during a trap stays pending in mip_o. It is normally masked afterwards because mstatus.mie is now 0.
- Unused mcause_o/mtval_o/mepc_o bits are driven from registered values and are don't-care when csr_we_o is 0.

## Timing
- Reset values: state IDLE, synchronizer flops 0, and every output 0 (busy_o, flush_req_o, csr_we_o, redirect_valid_o, all data outputs, mip_o).
- Assertion of rst_n at any point aborts the sequence immediately. No CSR write or redirect is issued afterwards.
- Trap latency, with the trigger in cycle 0:
  - flush_req_o is registered high in cycle 1.
  - If flush_ack_i is high in cycle 1, csr_we_o is high in cycle 2 and redirect_valid_o in cycle 3.
  - Every extra cycle without flush_ack_i adds one cycle.
- MRET latency: csr_we_o and redirect_valid_o are both high in cycle 1, and busy_o is high in cycle 1 only.
- flush_req_o drops in the cycle after flush_ack_i is sampled high.
- mip_o.meip lags ext_irq_i by 2 cycles.

## Configuration
- VECTORED_INT_EN defined: when mtvec_i[1:0] == 2'b01 and the cause is an interrupt, target = {mtvec_i[31:2], 2'b00} + 4 × cause[4:0]. Exceptions always use the base address.
- VECTORED_INT_EN undefined: mtvec_i[1:0] is ignored and the base address is always used.

## Structure
- Shared package riscV_unrn_pkg holds:
  - mstatus_csr_t, mip_csr_t, mie_csr_t, SUPPORTED_INTERRUPTS_MASK
  - the cause constants, with the interrupt causes defined as 32'h8000_000B and 32'h8000_0007 (bit XLEN-1 set explicitly)
  - a new trap_state_t enum: IDLE, FLUSH, COMMIT, REDIRECT, MRET
- Sub-module irq_sync: a 2-flop synchronizer with asynchronous active-low reset, instantiated for ext_irq_i.

## Test plan
- Illegal instruction: exc_valid_i with cause 2, pc 0x100, tval 0xFFFFFFFF, mtvec 0x200, flush_ack_i tied high → csr_we_o in cycle 2 with mepc 0x100, mcause 2, mtval 0xFFFFFFFF, mstatus.mie 0; redirect to 0x200 in cycle 3.
- External interrupt: mstatus.mie = 1, mie = 0x800, ext_irq_i rises, boundary_i high, next_pc_i = 0x44 → mcause 0x8000000B, mepc 0x44, mtval 0.
- Simultaneous external and timer interrupt (mie = 0x880) → mcause 0x8000000B. After MRET with the external line low, the timer interrupt is taken with mcause 0x80000007.
- Vectored mode, mtvec = 0x201, timer interrupt → redirect 0x21C with VECTORED_INT_EN defined, 0x200 without it.
- MRET with mstatus.mpie = 1, mepc 0x300 → in cycle 1, mstatus.mie = 1, mpie = 1, and redirect 0x300.
- flush_ack_i held low 5 cycles, then rst_n pulsed low → all outputs 0, state IDLE, no csr_we_o ever seen.
